rst_seq_ctl: RTL and testbench
==============================

RST_SEQ_CTL -- requirements
Module: rst_seq_ctl

Interface
REQ-001 Parameter NDOM, default 4: number of sequenced reset domains, minimum 1.
REQ-002 Parameter DLYW, default 8: width of dly_cfg.
REQ-003 Parameter QTO, default 1023: maximum number of cycles spent in the quiesce phase.
REQ-004 rclk  in  1  single block clock; all state changes on its rising edge.
REQ-005 arst_l  in  1  reset, asynchronous assert, active-low.
REQ-006 por_done_sync  in  1  power-on-done level, already synchronized to rclk upstream.
REQ-007 wrst_req  in  1  warm-reset request level.
REQ-008 quiesce_ack  in  1  fabric reports that traffic has drained.
REQ-009 dly_cfg  in  DLYW  spacing between sequence steps, in cycles.
REQ-010 clk_en  out  1  domain clock enable.
REQ-011 rst_l  out  NDOM  per-domain active-low resets; bit 0 is released first.
REQ-012 quiesce_req  out  1  drain request to the fabric.
REQ-013 wrst_ack  out  1  one-cycle pulse marking warm-reset completion.
REQ-014 seq_busy  out  1  high whenever the state is not RUN.

Function
REQ-015 All outputs SHALL be registered and SHALL update on the same edge as the state register.
REQ-016 FSM states SHALL be RESET, CLKON, REL, RUN, QUIESCE, ASSERT and HOLD.
REQ-017 Effective delay SHALL be D = max(dly_cfg, 1), sampled each time the delay counter is loaded.
REQ-018 RESET: all rst_l=0, clk_en=0; when por_done_sync=1 is sampled, go to CLKON.
REQ-019 CLKON: clk_en=1; stay D cycles, then go to REL with idx=0.
REQ-020 REL: on entry for idx, set rst_l[idx]=1; stay D cycles; then idx++, or go to RUN after idx=NDOM-1.
REQ-021 Timing: if por_done_sync is sampled at cycle t, then clk_en=1 at t+1, rst_l[i] rises at t+1+D*(i+1), and seq_busy falls at t+1+D*(NDOM+1).
REQ-022 RUN: when wrst_req=1 is sampled, go to QUIESCE; quiesce_req=1 from QUIESCE entry.
REQ-023 QUIESCE: go to ASSERT on the first cycle quiesce_ack=1 is sampled, or after QTO cycles in QUIESCE, whichever comes first.
REQ-024 ASSERT: lasts one cycle; all rst_l=0 and quiesce_req=0; clk_en stays 1 so the domains see reset with a running clock.
REQ-025 HOLD: clk_en=0; stay D cycles, then go to RESET and pulse wrst_ack=1 for that one cycle.
REQ-026 wrst_req SHALL be ignored in every state except RUN; a still-high wrst_req does not retrigger until RUN is re-entered.
REQ-027 por_done_sync=0 sampled in CLKON, REL, RUN or QUIESCE SHALL go to ASSERT directly, skipping quiesce; wrst_ack is still pulsed on exit from HOLD.
REQ-028 Simultaneous quiesce_ack and timeout SHALL be treated as ack; the exit cycle is the same either way.
REQ-029 A change of dly_cfg mid-step SHALL have no effect until the next counter load.

Reset
REQ-030 arst_l=0 SHALL immediately force: state=RESET, idx=0, counters=0, rst_l=0, clk_en=0, quiesce_req=0, wrst_ack=0, seq_busy=1.
REQ-031 Reset deassertion SHALL be followed by normal RESET-state behaviour; there is no self-release without por_done_sync.
REQ-032 arst_l asserted mid-sequence (any state) SHALL abort the sequence with no wrst_ack pulse.

Structure
REQ-033 The state encoding, the NDOM/DLYW/QTO defaults and the minimum-delay constant SHALL live in a shared package, rst_seq_pkg.
REQ-034 One sub-module, rst_seq_dly_cnt, SHALL provide the loadable down-counter with a done flag; it is shared by CLKON, REL, HOLD and the QUIESCE timeout.
REQ-035 The block SHALL contain no clock gating of its own; clk_en drives external gating cells.

Verification (NDOM=4, dly_cfg=3, QTO=1023)
REQ-036 Cold boot: por_done_sync sampled at cycle 10 -> clk_en@11, rst_l[0]@14, [1]@17, [2]@20, [3]@23, seq_busy=0@26.
REQ-037 Warm reset: wrst_req in RUN, quiesce_ack 5 cycles after quiesce_req -> ASSERT next cycle, rst_l=0, clk_en=0 for 3 cycles, wrst_ack pulse, then the full release sequence repeats.
REQ-038 Timeout: wrst_req with quiesce_ack held 0 -> ASSERT after exactly 1023 QUIESCE cycles.
REQ-039 dly_cfg=0 -> spacing of 1 cycle, so rst_l[3] rises 5 cycles after por_done_sync is sampled.
REQ-040 arst_l pulsed low during REL idx=2 -> outputs return to reset values asynchronously, no wrst_ack; the sequence restarts from por_done_sync.
REQ-041 por_done_sync dropped in RUN -> ASSERT next cycle with quiesce_req never raised, and wrst_ack on exit from HOLD.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   - seq_state_t : controller state encoding (also exported as debug state)
//   - NDOM_DEF / DLYW_DEF / QTO_DEF : default parameter values
//   - MIN_DLY     : smallest step spacing, applied when dly_cfg is zero
//   - state_is_busy / state_clk_on : per-state output decode helpers
package rst_seq_pkg;

  localparam int NDOM_DEF = 4;
  localparam int DLYW_DEF = 8;
  localparam int QTO_DEF  = 1023;

  localparam int unsigned MIN_DLY = 1;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_CLKON   = 3'd1,
    ST_REL     = 3'd2,
    ST_RUN     = 3'd3,
    ST_QUIESCE = 3'd4,
    ST_ASSERT  = 3'd5,
    ST_HOLD    = 3'd6
  } seq_state_t;

  // Everything except steady-state operation counts as "sequencing".
  function automatic logic state_is_busy(input seq_state_t s);
    return (s != ST_RUN);
  endfunction

  // The domain clock runs from CLKON through ASSERT, so domains enter reset
  // with a live clock and only lose it once HOLD begins.
  function automatic logic state_clk_on(input seq_state_t s);
    return (s == ST_CLKON) || (s == ST_REL) || (s == ST_RUN) ||
           (s == ST_QUIESCE) || (s == ST_ASSERT);
  endfunction

endpackage

// File: rtl/rst_seq_ctl_if.sv
// Bundle of the sequencer's control/status signals.
//   master modport : the sequencer (rst_seq_ctl)
//   slave modport  : the surrounding system / fabric
// Signals:
//   por_done_sync  power-on-done level, already in the rclk domain
//   wrst_req       warm-reset request level
//   quiesce_ack    fabric has drained
//   dly_cfg        spacing between sequence steps, in cycles
//   clk_en         enable for external clock gating cells
//   rst_l          per-domain active-low resets, bit 0 released first
//   quiesce_req    drain request to the fabric
//   wrst_ack       single-cycle warm-reset completion pulse
//   seq_busy       high while not in RUN
//   dbg_state      current controller state, for observation only
//
// Handshakes: both request/acknowledge pairs are level-request, event-ack.
// quiesce_req rises when draining starts and stays high until the sequencer
// leaves QUIESCE; quiesce_ack is only looked at while quiesce_req is high and
// a single sampled high cycle is enough. wrst_req is a level that is only
// looked at in RUN; completion is signalled by one wrst_ack cycle, after which
// the requester must drop wrst_req before the sequence returns to RUN or it
// will be taken as a new request.
interface rst_seq_ctl_if
  import rst_seq_pkg::*;
#(
  parameter int NDOM = NDOM_DEF,
  parameter int DLYW = DLYW_DEF
);

  logic            por_done_sync;
  logic            wrst_req;
  logic            quiesce_ack;
  logic [DLYW-1:0] dly_cfg;
  logic            clk_en;
  logic [NDOM-1:0] rst_l;
  logic            quiesce_req;
  logic            wrst_ack;
  logic            seq_busy;
  seq_state_t      dbg_state;

  modport master (
    input  por_done_sync, wrst_req, quiesce_ack, dly_cfg,
    output clk_en, rst_l, quiesce_req, wrst_ack, seq_busy, dbg_state
  );

  modport slave (
    output por_done_sync, wrst_req, quiesce_ack, dly_cfg,
    input  clk_en, rst_l, quiesce_req, wrst_ack, seq_busy, dbg_state
  );

endinterface

// File: rtl/rst_seq_dly_cnt.sv
// Loadable down-counter shared by every timed phase of the sequencer.
//   rclk, arst_l : clock and asynchronous active-low reset
//   load         : capture load_val this cycle (takes priority over counting)
//   load_val     : value loaded; a phase of N cycles loads N-1
//   done         : counter has reached zero
// The counter parks at zero, so done stays asserted until the next load.
module rst_seq_dly_cnt #(
  parameter int CW = 8
) (
  input  logic          rclk,
  input  logic          arst_l,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctl.sv
// Reset sequencer: brings NDOM reset domains out of reset in order after
// power-on, and runs warm resets (drain, assert, hold, re-release).
//   rclk   : block clock, all state changes on its rising edge
//   arst_l : asynchronous active-low reset, aborts any sequence in progress
//   bus    : rst_seq_ctl_if master modport (see interface for signal list)
// All outputs are registers computed from the next state, so they change on
// the same edge as the state register.
module rst_seq_ctl
  import rst_seq_pkg::*;
#(
  parameter int NDOM = NDOM_DEF,
  parameter int DLYW = DLYW_DEF,
  parameter int QTO  = QTO_DEF
) (
  input  logic          rclk,
  input  logic          arst_l,
  rst_seq_ctl_if.master bus
);

  localparam int IW = (NDOM > 1) ? $clog2(NDOM) : 1;
  localparam int QW = $clog2(QTO + 1);
  // The shared counter must hold both the largest step delay and the
  // quiesce timeout.
  localparam int CW = (DLYW > QW) ? DLYW : QW;

  localparam logic [CW-1:0] QTO_LOAD = CW'(QTO - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDOM - 1);

  seq_state_t      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [NDOM-1:0] rst_l_q, rst_l_d;
  logic            clk_en_q, clk_en_d;
  logic            quiesce_req_q, quiesce_req_d;
  logic            wrst_ack_q, wrst_ack_d;
  logic            seq_busy_q, seq_busy_d;

  logic            cnt_load;
  logic [CW-1:0]   cnt_load_val;
  logic            cnt_done;
  logic [CW-1:0]   dly_load;

  // A step lasts max(dly_cfg, MIN_DLY) cycles; the counter is loaded with one
  // less because the load cycle itself is the first cycle of the step.
  always_comb begin
    if (bus.dly_cfg < DLYW'(MIN_DLY)) begin
      dly_load = '0;
    end else begin
      dly_load = CW'(bus.dly_cfg) - CW'(MIN_DLY);
    end
  end

  rst_seq_dly_cnt #(
    .CW (CW)
  ) u_dly_cnt (
    .rclk     (rclk),
    .arst_l   (arst_l),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .done     (cnt_done)
  );

  // State and registered outputs.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q       <= ST_RESET;
      idx_q         <= '0;
      rst_l_q       <= '0;
      clk_en_q      <= 1'b0;
      quiesce_req_q <= 1'b0;
      wrst_ack_q    <= 1'b0;
      seq_busy_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rst_l_q       <= rst_l_d;
      clk_en_q      <= clk_en_d;
      quiesce_req_q <= quiesce_req_d;
      wrst_ack_q    <= wrst_ack_d;
      seq_busy_q    <= seq_busy_d;
    end
  end

  // Next state, counter control and next output values.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_load      = 1'b0;
    cnt_load_val  = dly_load;
    rst_l_d       = '0;
    clk_en_d      = 1'b0;
    quiesce_req_d = 1'b0;
    wrst_ack_d    = 1'b0;
    seq_busy_d    = 1'b1;

    unique case (state_q)
      ST_RESET: begin
        if (bus.por_done_sync) begin
          state_d  = ST_CLKON;
          cnt_load = 1'b1;
        end
      end

      // Losing power-good anywhere between clock-on and quiesce skips the
      // drain and goes straight to asserting reset.
      ST_CLKON: begin
        if (!bus.por_done_sync) begin
          state_d = ST_ASSERT;
        end else if (cnt_done) begin
          state_d  = ST_REL;
          idx_d    = '0;
          cnt_load = 1'b1;
        end
      end

      ST_REL: begin
        if (!bus.por_done_sync) begin
          state_d = ST_ASSERT;
        end else if (cnt_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            idx_d    = idx_q + 1'b1;
            cnt_load = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (!bus.por_done_sync) begin
          state_d = ST_ASSERT;
        end else if (bus.wrst_req) begin
          state_d      = ST_QUIESCE;
          cnt_load     = 1'b1;
          cnt_load_val = QTO_LOAD;
        end
      end

      // Ack and timeout landing together both simply leave for ASSERT.
      ST_QUIESCE: begin
        if (!bus.por_done_sync || bus.quiesce_ack || cnt_done) begin
          state_d = ST_ASSERT;
        end
      end

      ST_ASSERT: begin
        state_d  = ST_HOLD;
        idx_d    = '0;
        cnt_load = 1'b1;
      end

      ST_HOLD: begin
        if (cnt_done) begin
          state_d = ST_RESET;
        end
      end

      default: begin
        state_d = ST_RESET;
        idx_d   = '0;
      end
    endcase

    // Outputs follow the state being entered.
    clk_en_d      = state_clk_on(state_d);
    quiesce_req_d = (state_d == ST_QUIESCE);
    seq_busy_d    = state_is_busy(state_d);
    // Only a HOLD exit completes a warm reset; arst_l never reaches here.
    wrst_ack_d    = (state_q == ST_HOLD) && (state_d == ST_RESET);

    // In REL, every domain up to and including idx is out of reset.
    for (int i = 0; i < NDOM; i++) begin
      rst_l_d[i] = (state_d == ST_RUN) || (state_d == ST_QUIESCE) ||
                   ((state_d == ST_REL) && (IW'(i) <= idx_d));
    end
  end

  assign bus.rst_l       = rst_l_q;
  assign bus.clk_en      = clk_en_q;
  assign bus.quiesce_req = quiesce_req_q;
  assign bus.wrst_ack    = wrst_ack_q;
  assign bus.seq_busy    = seq_busy_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_rst_seq_ctl.sv
// Self-checking bench for rst_seq_ctl (NDOM=4, DLYW=8, QTO=1023).
// Inputs are driven and outputs checked on the falling edge. "Offset k" in
// the models is the number of cycles after the cycle in which a trigger
// (por_done_sync rising, wrst_req, por drop) was first sampled.
module tb_rst_seq_ctl;
  import rst_seq_pkg::*;

  localparam int NDOM = 4;
  localparam int DLYW = 8;
  localparam int QTO  = 1023;

  typedef struct packed {
    logic            clk_en;
    logic [NDOM-1:0] rst_l;
    logic            quiesce_req;
    logic            wrst_ack;
    logic            seq_busy;
  } outs_t;

  logic rclk;
  logic arst_l;

  int vectors;
  int miscompares;

  rst_seq_ctl_if #(.NDOM(NDOM), .DLYW(DLYW)) bus ();

  rst_seq_ctl #(
    .NDOM (NDOM),
    .DLYW (DLYW),
    .QTO  (QTO)
  ) dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .bus    (bus.master)
  );

  // ---------------- clock / reset ----------------
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // ---------------- reference model ----------------
  function automatic int eff(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic outs_t reset_vals();
    outs_t o;
    o.clk_en      = 1'b0;
    o.rst_l       = '0;
    o.quiesce_req = 1'b0;
    o.wrst_ack    = 1'b0;
    o.seq_busy    = 1'b1;
    return o;
  endfunction

  function automatic outs_t run_vals();
    outs_t o;
    o.clk_en      = 1'b1;
    o.rst_l       = '1;
    o.quiesce_req = 1'b0;
    o.wrst_ack    = 1'b0;
    o.seq_busy    = 1'b0;
    return o;
  endfunction

  // Release timeline: clock on one cycle after por is sampled, clock-on phase
  // of dc cycles, then one domain every dr cycles, then RUN after the last.
  function automatic outs_t boot_exp(input int k, input int dc, input int dr);
    outs_t o;
    o = reset_vals();
    if (k >= 1) o.clk_en = 1'b1;
    for (int i = 0; i < NDOM; i++) begin
      if (k >= 1 + dc + dr * i) o.rst_l[i] = 1'b1;
    end
    if (k >= 1 + dc + dr * NDOM) o.seq_busy = 1'b0;
    return o;
  endfunction

  // Warm-reset timeline: q cycles draining (0 when power-good drops), one
  // assert cycle with the clock still on, d cycles held with the clock off,
  // then RESET carrying the ack pulse, optionally followed by a full release.
  function automatic outs_t warm_exp(input int k, input int q, input int d,
                                     input bit reboot);
    outs_t o;
    int    r;
    if (k == 0) begin
      o = run_vals();
    end else if (k <= q) begin
      o = run_vals();
      o.quiesce_req = 1'b1;
      o.seq_busy    = 1'b1;
    end else if (k == q + 1) begin
      o = reset_vals();
      o.clk_en = 1'b1;
    end else if (k <= q + 1 + d) begin
      o = reset_vals();
    end else begin
      r = k - (q + 2 + d);
      o = reboot ? boot_exp(r, d, d) : reset_vals();
      if (r == 0) o.wrst_ack = 1'b1;
    end
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input outs_t exp);
    outs_t obs;
    obs = {bus.clk_en, bus.rst_l, bus.quiesce_req, bus.wrst_ack, bus.seq_busy};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t state=%s: observed clk_en=%b rst_l=%b qreq=%b wack=%b busy=%b, expected clk_en=%b rst_l=%b qreq=%b wack=%b busy=%b",
             tag, $time, bus.dbg_state.name(),
             obs.clk_en, obs.rst_l, obs.quiesce_req, obs.wrst_ack, obs.seq_busy,
             exp.clk_en, exp.rst_l, exp.quiesce_req, exp.wrst_ack, exp.seq_busy);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called from RESET. d0 sets the clock-on spacing, d1 is applied during the
  // first clock-on cycle and governs the releases. arst_k > 0 pulses arst_l
  // mid-cycle at that offset, after which the release restarts from offset 1.
  task automatic do_boot(input string tag, input int d0, input int d1,
                         input int arst_k);
    int dc, dr, kend, k;
    bit hit;
    bus.dly_cfg = DLYW'(d0);
    dc   = eff(d0);
    dr   = eff(d1);
    check({tag, "_k0"}, reset_vals());
    bus.por_done_sync = 1'b1;
    kend = 2 + dc + dr * NDOM;
    k    = 1;
    hit  = 1'b0;
    while (k <= kend) begin
      @(negedge rclk);
      check(tag, boot_exp(k, dc, dr));
      if (k == 1) bus.dly_cfg = DLYW'(d1);
      if (!hit && k == arst_k) begin
        hit = 1'b1;
        #2 arst_l = 1'b0;
        #1 check({tag, "_arst"}, reset_vals());
        #1 arst_l = 1'b1;
        dc   = dr;
        kend = 2 + dc + dr * NDOM;
        k    = 0;
      end
      k++;
    end
  endtask

  // Called from RUN. a = offset at which quiesce_ack is presented (0 = never),
  // hold_w = offset at which wrst_req drops, drop = use power-good loss
  // instead of wrst_req.
  task automatic do_warm(input string tag, input int a, input int hold_w,
                         input bit drop);
    int d, q, kend;
    d = eff(int'(bus.dly_cfg));
    if (drop)                 q = 0;
    else if (a == 0 || a > QTO) q = QTO;
    else                      q = a;
    check({tag, "_k0"}, run_vals());
    if (drop) bus.por_done_sync = 1'b0;
    else      bus.wrst_req      = 1'b1;
    kend = q + 2 + d + (drop ? 3 : 2 + d * (NDOM + 1));
    for (int k = 1; k <= kend; k++) begin
      @(negedge rclk);
      check(tag, warm_exp(k, q, d, !drop));
      if (k == hold_w) bus.wrst_req = 1'b0;
      bus.quiesce_ack = (!drop && k == a);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int a, h;
    vectors     = 0;
    miscompares = 0;
    arst_l            = 1'b0;
    bus.por_done_sync = 1'b0;
    bus.wrst_req      = 1'b0;
    bus.quiesce_ack   = 1'b0;
    bus.dly_cfg       = 8'd3;

    repeat (3) @(negedge rclk);
    check("in_reset", reset_vals());
    arst_l = 1'b1;
    // No release without power-good, even with a warm request present.
    bus.wrst_req = 1'b1;
    repeat (6) begin
      @(negedge rclk);
      check("idle_no_por", reset_vals());
    end
    bus.wrst_req = 1'b0;

    do_boot("cold_d3", 3, 3, 0);
    do_warm("warm_ack5", 5, 1, 1'b0);
    do_warm("warm_timeout", 0, 4, 1'b0);
    do_warm("por_drop", 0, 0, 1'b1);
    do_boot("arst_rel2", 3, 3, 11);
    do_warm("por_drop2", 0, 0, 1'b1);
    do_boot("cold_d0", 0, 0, 0);
    do_warm("por_drop3", 0, 0, 1'b1);
    do_boot("dly_midstep", 3, 5, 0);

    for (int n = 0; n < 8; n++) begin
      bus.dly_cfg = DLYW'($urandom_range(0, 4));
      @(negedge rclk);
      check("run_cfg", run_vals());
      a = $urandom_range(1, 12);
      h = $urandom_range(1, a + 1);
      do_warm("rand_warm", a, h, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
